// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_control                                                         |
// | Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing,     |
// | memory wait timeout, illegal-opcode trap and retired-instruction counter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic          mem_ready,
  output logic          RegWrite,
  output logic          RegRead,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          toReg,
  output logic          rt_rd,
  output logic          PCWrite,
  output logic          IRWrite,
  output logic [2:0]    state,
  output logic          illegal,
  output logic          mem_timeout,
  output logic [RW-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ILLEGAL = 3'd0,
    C_R       = 3'd1,
    C_JR      = 3'd2,
    C_LOAD    = 3'd3,
    C_STORE   = 3'd4,
    C_ALUI    = 3'd5,
    C_JAL     = 3'd6,
    C_BR      = 3'd7
  } class_e;

  localparam int            WCW        = 8;
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  class_e          cls_q, cls_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic [RW-1:0]   retired_q, retired_d;
  class_e          w_class;
  logic            w_waiting;
  logic            w_retire;

  function automatic class_e decode_class(input logic [5:0] op, input logic [5:0] fn);
    class_e c;
    case (op)
      6'b000000:                       c = (fn == 6'b001000) ? C_JR : C_R;
      6'b100000, 6'b100001, 6'b100011: c = C_LOAD;
      6'b101000, 6'b101001, 6'b101011: c = C_STORE;
      6'b001000, 6'b001100, 6'b001101,
      6'b001010, 6'b001111:            c = C_ALUI;
      6'b000011:                       c = C_JAL;
      6'b000100, 6'b000101, 6'b000001: c = C_BR;
      default:                         c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic reads_regs(input class_e c);
    return (c != C_JAL) && (c != C_ILLEGAL);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ILLEGAL;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    w_class   = decode_class(opcode, funct);
    w_waiting = 1'b0;
    RegWrite  = 1'b0;
    RegRead   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    toReg     = 1'b0;
    rt_rd     = 1'b1;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_DECODE: begin
        // The live opcode is decoded here; later states see only the latched class.
        cls_d   = w_class;
        RegRead = reads_regs(w_class);
        if (w_class == C_ILLEGAL) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        RegRead = reads_regs(cls_q);
        case (cls_q)
          C_BR, C_JR: begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE:   state_d = S_MEM;
          C_R, C_ALUI, C_JAL: state_d = S_WB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        MemRead  = (cls_q == C_LOAD);
        MemWrite = (cls_q == C_STORE);
        if (mem_ready) begin
          state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        toReg    = (cls_q == C_LOAD);
        rt_rd    = (cls_q != C_R);
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        rt_rd = 1'b0;
      end
      default: begin
        rt_rd   = 1'b0;
        state_d = S_TRAP;
      end
    endcase

    // This cycle would be wait number MEM_TIMEOUT; a ready memory never reaches here.
    if (w_waiting && (wait_q == WAIT_LIMIT)) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end

    wait_d = (w_waiting && (state_d == state_q)) ? wait_q + 1'b1 : '0;

    w_retire  = (state_d == S_FETCH) &&
                ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));
    retired_d = (w_retire && (retired_q != {RW{1'b1}})) ? retired_q + 1'b1 : retired_q;

    // FETCH must not load the IR or PC while reset is held, whatever mem_ready says.
    if (reset) begin
      IRWrite = 1'b0;
      PCWrite = 1'b0;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_control                                                      |
// | Instruction-level reference model driving two controller instances.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

  localparam logic [7:0] B_RW = 8'h80, B_RR = 8'h40, B_MR = 8'h20, B_MW = 8'h10;
  localparam logic [7:0] B_TR = 8'h08, B_RT = 8'h04, B_PC = 8'h02, B_IR = 8'h01;
  localparam int K_R = 0, K_JR = 1, K_LOAD = 2, K_STORE = 3, K_ALUI = 4, K_JAL = 5, K_BR = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;

  logic a_RegWrite, a_RegRead, a_MemRead, a_MemWrite, a_toReg, a_rt_rd, a_PCWrite, a_IRWrite;
  logic b_RegWrite, b_RegRead, b_MemRead, b_MemWrite, b_toReg, b_rt_rd, b_PCWrite, b_IRWrite;
  logic [2:0]  a_state, b_state;
  logic        a_illegal, b_illegal, a_mem_timeout, b_mem_timeout;
  logic [1:0]  a_retired;
  logic [15:0] b_retired;

  wire [7:0] a_ctrl = {a_RegWrite, a_RegRead, a_MemRead, a_MemWrite, a_toReg, a_rt_rd, a_PCWrite, a_IRWrite};
  wire [7:0] b_ctrl = {b_RegWrite, b_RegRead, b_MemRead, b_MemWrite, b_toReg, b_rt_rd, b_PCWrite, b_IRWrite};

  multicycle_control #(.MEM_TIMEOUT(4), .RW(2)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .RegWrite(a_RegWrite), .RegRead(a_RegRead), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
    .toReg(a_toReg), .rt_rd(a_rt_rd), .PCWrite(a_PCWrite), .IRWrite(a_IRWrite),
    .state(a_state), .illegal(a_illegal), .mem_timeout(a_mem_timeout), .retired(a_retired)
  );

  multicycle_control #(.MEM_TIMEOUT(16), .RW(16)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .RegWrite(b_RegWrite), .RegRead(b_RegRead), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .toReg(b_toReg), .rt_rd(b_rt_rd), .PCWrite(b_PCWrite), .IRWrite(b_IRWrite),
    .state(b_state), .illegal(b_illegal), .mem_timeout(b_mem_timeout), .retired(b_retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ret_a  = 0;
  int ret_b  = 0;

  logic [5:0] ld_ops [3] = '{6'b100000, 6'b100001, 6'b100011};
  logic [5:0] st_ops [3] = '{6'b101000, 6'b101001, 6'b101011};
  logic [5:0] ai_ops [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111};
  logic [5:0] br_ops [3] = '{6'b000100, 6'b000101, 6'b000001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive mem_ready at the falling edge, check, then advance one full cycle.
  task automatic step(input logic mr, input int st, input logic [7:0] ctl, input bit with_b);
    mem_ready = mr;
    #1;
    chk("a_state", 32'(a_state), 32'(st));
    chk("a_ctrl", 32'(a_ctrl), 32'(ctl));
    if (with_b) begin
      chk("b_state", 32'(b_state), 32'(st));
      chk("b_ctrl", 32'(b_ctrl), 32'(ctl));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_retired();
    #1;
    chk("a_retired", 32'(a_retired), 32'(ret_a));
    chk("b_retired", 32'(b_retired), 32'(ret_b));
  endtask

  // Reset is raised mid-cycle so its effect is only visible if it is asynchronous.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_ctrl", 32'(a_ctrl), 32'(B_MR | B_RT));
    chk("rst_retired", 32'(a_retired), 32'd0);
    chk("rst_illegal", 32'(a_illegal), 32'd0);
    chk("rst_timeout", 32'(a_mem_timeout), 32'd0);
    chk("rst_b_state", 32'(b_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ret_a = 0;
    ret_b = 0;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One complete legal instruction, expected behaviour derived from its class alone.
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                           input int fwait, input int mwait);
    logic       rr;
    logic [7:0] ex;
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fwait; i++) step(1'b0, 0, B_MR | B_RT, 1'b1);
    step(1'b1, 0, B_MR | B_RT | B_PC | B_IR, 1'b1);
    rr = (k != K_JAL);
    step(rnd_bit(), 1, (rr ? B_RR : 8'h00) | B_RT, 1'b1);
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    ex = (rr ? B_RR : 8'h00) | B_RT | ((k == K_BR || k == K_JR) ? B_PC : 8'h00);
    step(rnd_bit(), 2, ex, 1'b1);
    if (k == K_LOAD || k == K_STORE) begin
      ex = B_RT | ((k == K_LOAD) ? B_MR : B_MW);
      for (int i = 0; i < mwait; i++) step(1'b0, 3, ex, 1'b1);
      step(1'b1, 3, ex, 1'b1);
    end
    if (k == K_LOAD || k == K_R || k == K_ALUI || k == K_JAL)
      step(rnd_bit(), 4, B_RW | ((k == K_LOAD) ? B_TR : 8'h00) | ((k == K_R) ? 8'h00 : B_RT), 1'b1);
    ret_a = (ret_a < 3) ? ret_a + 1 : 3;
    ret_b = ret_b + 1;
    check_retired();
  endtask

  initial begin
    int         k;
    logic [5:0] op, fn;

    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    funct = 6'b100000;
    #2;
    chk("reset_state", 32'(a_state), 32'd0);
    chk("reset_ctrl", 32'(a_ctrl), 32'(B_MR | B_RT));
    chk("reset_retired", 32'(a_retired), 32'd0);
    chk("reset_sticky", 32'({a_illegal, a_mem_timeout}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed: add, lw with 3 MEM waits, sw, jr, jal -> RW=2 counter saturates.
    run_instr(K_R,     6'b000000, 6'b100000, 0, 0);
    run_instr(K_LOAD,  6'b100011, 6'b000000, 0, 3);
    run_instr(K_STORE, 6'b101011, 6'b000000, 0, 0);
    run_instr(K_JR,    6'b000000, 6'b001000, 0, 0);
    run_instr(K_JAL,   6'b000011, 6'b000000, 1, 0);

    // Random legal instructions with memory waits up to the boundary cycle.
    for (int n = 0; n < 40; n++) begin
      k  = int'($urandom_range(0, 6));
      fn = 6'($urandom);
      case (k)
        K_R:     begin op = 6'b000000; if (fn == 6'b001000) fn = 6'b100000; end
        K_JR:    begin op = 6'b000000; fn = 6'b001000; end
        K_LOAD:  op = ld_ops[$urandom_range(0, 2)];
        K_STORE: op = st_ops[$urandom_range(0, 2)];
        K_ALUI:  op = ai_ops[$urandom_range(0, 4)];
        K_JAL:   op = 6'b000011;
        default: op = br_ops[$urandom_range(0, 2)];
      endcase
      run_instr(k, op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Illegal opcode: trap with every control low, held for 20 cycles.
    opcode = 6'b111111;
    funct = 6'b000000;
    step(1'b1, 0, B_MR | B_RT | B_PC | B_IR, 1'b1);
    step(1'b1, 1, B_RT, 1'b1);
    for (int i = 0; i < 20; i++) step(rnd_bit(), 5, 8'h00, 1'b1);
    #1;
    chk("illegal_set", 32'(a_illegal), 32'd1);
    chk("illegal_b_set", 32'(b_illegal), 32'd1);
    chk("illegal_no_timeout", 32'(a_mem_timeout), 32'd0);
    check_retired();
    pulse_reset();

    // Fetch timeout: four waiting cycles trap the short-timeout instance.
    for (int i = 0; i < 4; i++) step(1'b0, 0, B_MR | B_RT, 1'b0);
    #1;
    chk("fetch_to_state", 32'(a_state), 32'd5);
    chk("fetch_to_flag", 32'(a_mem_timeout), 32'd1);
    chk("fetch_to_ctrl", 32'(a_ctrl), 32'd0);
    chk("fetch_to_illegal", 32'(a_illegal), 32'd0);
    pulse_reset();

    // Ready on the fourth waiting cycle completes normally.
    run_instr(K_ALUI, 6'b001101, 6'b000000, 3, 0);
    #1;
    chk("boundary_no_timeout", 32'(a_mem_timeout), 32'd0);

    // Load stuck in MEM traps after four wait cycles.
    opcode = 6'b100001;
    step(1'b1, 0, B_MR | B_RT | B_PC | B_IR, 1'b1);
    step(1'b0, 1, B_RR | B_RT, 1'b1);
    step(1'b0, 2, B_RR | B_RT, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 3, B_MR | B_RT, 1'b0);
    #1;
    chk("mem_to_state", 32'(a_state), 32'd5);
    chk("mem_to_flag", 32'(a_mem_timeout), 32'd1);
    chk("mem_to_b_state", 32'(b_state), 32'd3);
    pulse_reset();

    // Store abandoned by reset while MemWrite is high.
    opcode = 6'b101001;
    step(1'b1, 0, B_MR | B_RT | B_PC | B_IR, 1'b1);
    step(1'b0, 1, B_RR | B_RT, 1'b1);
    step(1'b0, 2, B_RR | B_RT, 1'b1);
    step(1'b0, 3, B_MW | B_RT, 1'b1);
    mem_ready = 1'b0;
    pulse_reset();
    check_retired();
    run_instr(K_BR, 6'b000100, 6'b000000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max consecutive wait cycles on mem_ready before trap (range 2..255).
REQ-002 SHALL have parameter RW, default 16: width of retired-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port opcode  input  6  instruction opcode, stable from IR after FETCH.
REQ-006 SHALL have port funct  input  6  R-type function field.
REQ-007 SHALL have port mem_ready  input  1  memory completes current access this cycle.
REQ-008 SHALL have ports RegWrite, RegRead, MemRead, MemWrite, toReg, rt_rd  output  1 each  datapath controls (toReg 0=ALU, 1=mem; rt_rd 0=rd, 1=rt).
REQ-009 SHALL have ports PCWrite, IRWrite  output  1 each  PC update, instruction register load.
REQ-010 SHALL have port state  output  3  current state encoding.
REQ-011 SHALL have ports illegal, mem_timeout  output  1 each  sticky trap causes.
REQ-012 SHALL have port retired  output  RW  count of completed instructions.

Function
REQ-013 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6,7 go to TRAP next cycle.
REQ-014 SHALL latch opcode/funct into internal class register on the DECODE edge; EXEC/MEM/WB decode only from latched class.
REQ-015 Classes: R (op 000000, funct != 001000), JR (op 000000, funct 001000), LOAD (100000/100001/100011), STORE (101000/101001/101011), ALUI (001000/001100/001101/001010/001111), JAL (000011), BR (000100/000101/000001); all others ILLEGAL.
REQ-016 FETCH: MemRead=1; stay while mem_ready=0; on mem_ready=1 assert IRWrite=1 and PCWrite=1 that cycle, go DECODE.
REQ-017 DECODE: RegRead=1 for every class except JAL and ILLEGAL; ILLEGAL -> TRAP with illegal set; else -> EXEC.
REQ-018 EXEC: RegRead as in DECODE; BR and JR assert PCWrite=1 and go FETCH; LOAD/STORE -> MEM; R/ALUI/JAL -> WB.
REQ-019 MEM: LOAD drives MemRead=1, STORE drives MemWrite=1, held until mem_ready=1; then LOAD -> WB, STORE -> FETCH.
REQ-020 WB: RegWrite=1, one cycle; toReg=1 only for LOAD; rt_rd=0 only for R, else 1; -> FETCH.
REQ-021 Outputs not listed for a state SHALL be 0, except rt_rd which SHALL default to 1.
REQ-022 Wait counter SHALL count consecutive cycles in FETCH or MEM with mem_ready=0, clear on mem_ready=1 or state change.
REQ-023 When wait counter reaches MEM_TIMEOUT with mem_ready still 0, next state SHALL be TRAP and mem_timeout set; mem_ready=1 on that same cycle wins (normal completion, no trap).
REQ-024 TRAP: all datapath controls 0, PCWrite/IRWrite 0; remains until reset; illegal/mem_timeout sticky.
REQ-025 retired SHALL increment on each transition into FETCH from EXEC, MEM or WB; saturates at all-ones.
REQ-026 Instruction latency: R/ALUI/JAL 4 cycles, BR/JR 3, STORE 4, LOAD 5, each plus memory wait cycles.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force state=FETCH, wait counter 0, retired 0, illegal 0, mem_timeout 0, class register 0.
REQ-028 Outputs during reset SHALL be FETCH values with mem_ready ignored for state advance: MemRead=1, rt_rd=1, others 0.
REQ-029 Reset asserted mid-instruction (any state, incl. MEM with MemWrite=1) SHALL abandon it without incrementing retired.

Verification
REQ-030 add (op 000000, funct 100000), mem_ready=1 in FETCH -> states 0,1,2,4,0; WB: RegWrite=1, rt_rd=0, toReg=0; retired 0->1.
REQ-031 lw (100011), mem_ready low 3 cycles in MEM -> MemRead held 4 MEM cycles; WB toReg=1, rt_rd=1; total 8 cycles.
REQ-032 sw (101011) -> MEM MemWrite=1, no WB state, RegWrite never 1; retired increments on MEM->FETCH.
REQ-033 opcode 111111 -> DECODE->TRAP, illegal=1, all controls 0 for 20 cycles; reset -> FETCH, illegal=0.
REQ-034 mem_ready held 0 in FETCH, MEM_TIMEOUT=4 -> TRAP after 4 wait cycles, mem_timeout=1; repeat with mem_ready=1 on 4th cycle -> DECODE, no trap.
REQ-035 jr (000000/001000) -> EXEC PCWrite=1, no WB; RW=2 with 5 instructions -> retired saturates at 3.
